eval_scheduler: RTL and testbench

- Front-end sequencer for the generated RTLola monitor datapath.
- Turns input arrivals and the periodic pacing timer into timestamped evaluation events, buffers them in a small queue, then steps the stream-evaluation layers one per cycle for each event.
- Drives the pacing (event / periodic) and per-layer enables consumed by the stream datapath.
- Exposes the queue push/pop handshake for the testbench.

---
 rtl/eval_sched_pkg.sv | 24 ++
 rtl/event_fifo.sv | 53 +++++
 rtl/eval_scheduler.sv | 173 +++++++++++++++++
 tb/tb_eval_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/eval_sched_pkg.sv
// Shared types and default sizing for the RTLola evaluation scheduler.
// The event record is the unit buffered between arrival and layer stepping.
package eval_sched_pkg;

  localparam int DEF_DATA_W        = 64;
  localparam int DEF_TS_W          = 32;
  localparam int DEF_PERIOD_CYCLES = 50;
  localparam int DEF_NUM_LAYERS    = 4;
  localparam int DEF_QUEUE_DEPTH   = 4;

  typedef enum logic {
    IDLE,
    EVAL
  } sched_state_e;

  // Record layout at default widths; the top re-declares it with its own widths.
  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] data;
    logic [DEF_TS_W-1:0]          ts;
    logic                         has_input;
    logic                         periodic;
  } ev_rec_t;

endpackage

// File: rtl/event_fifo.sv
// Single-clock circular queue of event records with occupancy count.
// A pop and a push in the same cycle are both honoured even when full.
module event_fifo #(
  parameter int  DEPTH = 4,
  parameter type rec_t = logic
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  rec_t                   i_data,
  input  logic                   i_pop,
  output rec_t                   o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rec_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/eval_scheduler.sv
// Front-end sequencer: merges input arrivals and periodic ticks into timestamped
// events, queues them, and steps the evaluation layers one per cycle per event.
module eval_scheduler
  import eval_sched_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int TS_W          = DEF_TS_W,
  parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int NUM_LAYERS    = DEF_NUM_LAYERS,
  parameter int QUEUE_DEPTH   = DEF_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] input_0,
  input  logic                     new_input_0,
  output logic                     q_push,
  output logic                     q_push_valid,
  output logic                     q_pop,
  output logic                     q_pop_valid,
  output logic signed [DATA_W-1:0] ev_data,
  output logic [TS_W-1:0]          ev_ts,
  output logic                     pacing_event,
  output logic                     pacing_periodic,
  output logic [NUM_LAYERS-1:0]    layer_en,
  output logic                     eval_busy,
  output logic                     eval_done,
  output logic                     overflow
);

  localparam int PER_W = $clog2(PERIOD_CYCLES);
  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  typedef struct packed {
    logic signed [DATA_W-1:0] data;
    logic [TS_W-1:0]          ts;
    logic                     has_input;
    logic                     periodic;
  } event_t;

  sched_state_e          r_state;
  sched_state_e          w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [TS_W-1:0]       r_ts;
  logic [PER_W-1:0]      r_per;
  logic                  r_overflow;
  logic signed [DATA_W-1:0] r_ev_data;
  logic [TS_W-1:0]       r_ev_ts;
  logic                  r_pacing_event;
  logic                  r_pacing_periodic;

  logic                  w_run;
  logic                  w_tick;
  logic                  w_push_req;
  logic                  w_push_ok;
  logic                  w_pop;
  logic                  w_done;
  logic [NUM_LAYERS-1:0] w_layer_en;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  event_t                w_rec;
  event_t                w_head;

  assign w_run      = rst & en;
  assign w_tick     = (r_per == PER_W'(PERIOD_CYCLES - 1));
  assign w_push_req = w_run & (new_input_0 | w_tick);
  assign w_push_ok  = w_push_req & (~w_full | w_pop);

  // A coincident input and tick share one record.
  always_comb begin
    w_rec           = '0;
    w_rec.data      = new_input_0 ? input_0 : '0;
    w_rec.ts        = r_ts;
    w_rec.has_input = new_input_0;
    w_rec.periodic  = w_tick;
  end

  event_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .rec_t (event_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_ok),
    .i_data  (w_rec),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else if (en) begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_layer_en  = '0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = w_run;
          w_state_nxt = EVAL;
          w_idx_nxt   = '0;
        end
      end
      EVAL: begin
        w_layer_en = NUM_LAYERS'(1) << r_idx;
        if (r_idx == IDX_W'(NUM_LAYERS - 1)) begin
          w_done      = w_run;
          w_state_nxt = IDLE;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ts              <= '0;
      r_per             <= '0;
      r_overflow        <= 1'b0;
      r_ev_data         <= '0;
      r_ev_ts           <= '0;
      r_pacing_event    <= 1'b0;
      r_pacing_periodic <= 1'b0;
    end else if (en) begin
      r_ts  <= r_ts + 1'b1;
      r_per <= w_tick ? '0 : r_per + 1'b1;
      if (w_push_req && !w_push_ok) r_overflow <= 1'b1;
      if (w_pop) begin
        r_ev_data         <= w_head.data;
        r_ev_ts           <= w_head.ts;
        r_pacing_event    <= w_head.has_input;
        r_pacing_periodic <= w_head.periodic;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) assert (w_count <= CNT_W'(QUEUE_DEPTH));
  end

  assign q_push          = w_push_req;
  assign q_push_valid    = w_push_ok;
  assign q_pop           = w_pop;
  assign q_pop_valid     = w_pop;
  assign ev_data         = r_ev_data;
  assign ev_ts           = r_ev_ts;
  assign pacing_event    = r_pacing_event;
  assign pacing_periodic = r_pacing_periodic;
  assign layer_en        = w_layer_en;
  assign eval_busy       = (r_state != IDLE);
  assign eval_done       = w_done;
  assign overflow        = r_overflow;

endmodule

// File: tb/tb_eval_scheduler.sv
// Directed bench for eval_scheduler at default parameters (PERIOD_CYCLES=50, 4 layers, depth 4).
// Cycle n is the n-th cycle after reset release; ts equals n while en stays high.
module tb_eval_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [63:0] input_0;
  logic        new_input_0;
  logic        q_push, q_push_valid, q_pop, q_pop_valid;
  logic [63:0] ev_data;
  logic [31:0] ev_ts;
  logic        pacing_event, pacing_periodic;
  logic [3:0]  layer_en;
  logic        eval_busy, eval_done, overflow;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;
  int done_cnt = 0;
  logic [63:0] done_q [$];

  eval_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .input_0         (input_0),
    .new_input_0     (new_input_0),
    .q_push          (q_push),
    .q_push_valid    (q_push_valid),
    .q_pop           (q_pop),
    .q_pop_valid     (q_pop_valid),
    .ev_data         (ev_data),
    .ev_ts           (ev_ts),
    .pacing_event    (pacing_event),
    .pacing_periodic (pacing_periodic),
    .layer_en        (layer_en),
    .eval_busy       (eval_busy),
    .eval_done       (eval_done),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, {q_push, q_push_valid, q_pop, q_pop_valid, ev_data, ev_ts, pacing_event,
                pacing_periodic, layer_en, eval_busy, eval_done, overflow}, '0);
  endtask

  // Sample the closing cycle's pulses, then move to the next cycle window.
  task automatic next();
    #3;
    if (q_push) push_cnt++;
    if (q_pop)  pop_cnt++;
    if (eval_done) begin
      done_cnt++;
      done_q.push_back(ev_data);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) next();
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b0; en = 1'b1; new_input_0 = 1'b0; input_0 = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
      check_zero("reset_outputs");
    end
    rst = 1'b1;
    cyc = 0; push_cnt = 0; pop_cnt = 0; done_cnt = 0;
    done_q.delete();
  endtask

  logic [9:0] acc_exp;
  logic [3:0] exp_le;
  int         exp_ord [6] = '{0, 1, 2, 3, 4, 6};

  initial begin
    rst = 1'b0; en = 1'b1; new_input_0 = 1'b0; input_0 = '0;

    // Reset, first periodic tick at cycle 49.
    reset_dut(3);
    #1; check("c0_no_push", q_push, 1'b0);
    goto(49); #1;
    check("tick_push", q_push, 1'b1);
    check("tick_push_valid", q_push_valid, 1'b1);
    goto(50); #1;
    check("tick_pop", {q_pop, q_pop_valid}, 2'b11);
    goto(51); #1;
    check("tick_layer0", layer_en, 4'b0001);
    check("tick_ts", ev_ts, 32'd49);
    check("tick_pacing", {pacing_event, pacing_periodic}, 2'b01);
    check("tick_busy", eval_busy, 1'b1);

    // Single input at cycle 10, then coincident input+tick at 49.
    reset_dut(3);
    goto(10); new_input_0 = 1'b1; input_0 = 64'd5; #1;
    check("single_push", {q_push, q_push_valid}, 2'b11);
    goto(11); new_input_0 = 1'b0; #1;
    check("single_pop", {q_pop, q_pop_valid}, 2'b11);
    for (int l = 0; l < 4; l++) begin
      goto(12 + l); #1;
      exp_le = 4'b0001 << l;
      check("single_layer", layer_en, exp_le);
      check("single_done", eval_done, (l == 3));
      if (l == 0) begin
        check("single_data", ev_data, 64'd5);
        check("single_ts", ev_ts, 32'd10);
        check("single_pacing", {pacing_event, pacing_periodic}, 2'b10);
      end
    end
    goto(16); #1;
    check("single_idle_layer", {layer_en, eval_busy}, 5'b0);
    check("single_hold_data", ev_data, 64'd5);
    check("single_done_cnt", done_cnt, 1);

    goto(49); new_input_0 = 1'b1; input_0 = 64'd7; #1;
    check("coinc_push", {q_push, q_push_valid}, 2'b11);
    goto(50); new_input_0 = 1'b0; #1;
    check("coinc_pop", q_pop, 1'b1);
    goto(51); #1;
    check("coinc_data", ev_data, 64'd7);
    check("coinc_ts", ev_ts, 32'd49);
    check("coinc_pacing", {pacing_event, pacing_periodic}, 2'b11);
    check("coinc_layer0", layer_en, 4'b0001);
    goto(56); #1;
    check("coinc_one_push", push_cnt, 2);
    check("coinc_done_cnt", done_cnt, 2);

    // Overflow: inputs every cycle 0..9.
    reset_dut(3);
    acc_exp = 10'b0001011111;
    for (int i = 0; i < 10; i++) begin
      goto(i); new_input_0 = 1'b1; input_0 = 64'(i); #1;
      check("ovf_accept", q_push_valid, acc_exp[i]);
      check("ovf_flag", overflow, (i >= 6));
    end
    goto(10); new_input_0 = 1'b0;
    goto(40); #1;
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_done_count", done_q.size(), 6);
    for (int k = 0; k < 6; k++) check("ovf_order", done_q[k], 64'(exp_ord[k]));

    // Clock enable dropped for 3 cycles while layer 1 is active.
    reset_dut(3);
    goto(10); new_input_0 = 1'b1; input_0 = 64'd9;
    goto(11); new_input_0 = 1'b0;
    goto(13); #1;
    check("en_layer1", layer_en, 4'b0010);
    en = 1'b0; new_input_0 = 1'b1; input_0 = 64'd123; #1;
    check("en_no_push", {q_push, q_push_valid}, 2'b00);
    goto(14); #1;
    check("en_hold_layer", layer_en, 4'b0010);
    check("en_hold_ts", ev_ts, 32'd10);
    check("en_no_done", eval_done, 1'b0);
    goto(15); #1;
    check("en_hold_layer2", layer_en, 4'b0010);
    goto(16); en = 1'b1; new_input_0 = 1'b0; #1;
    check("en_resume_layer1", layer_en, 4'b0010);
    goto(17); #1;
    check("en_resume_layer2", layer_en, 4'b0100);
    goto(18); #1;
    check("en_resume_done", {layer_en, eval_done}, 5'b10001);
    goto(20); new_input_0 = 1'b1; input_0 = 64'h42;
    goto(21); new_input_0 = 1'b0;
    goto(22); #1;
    check("en_ts_frozen", ev_ts, 32'd17);
    check("en_data", ev_data, 64'h42);
    goto(23); #1;
    check("en_push_cnt", push_cnt, 2);

    // Reset mid-evaluation with two events queued.
    reset_dut(3);
    goto(10); new_input_0 = 1'b1; input_0 = 64'd1;
    goto(11); input_0 = 64'd2;
    goto(12); input_0 = 64'd3;
    goto(13); new_input_0 = 1'b0;
    goto(14); #1;
    check("mid_layer2", layer_en, 4'b0100);
    reset_dut(1);
    goto(20); #1;
    check("mid_no_pop", pop_cnt, 0);
    check("mid_no_done", done_cnt, 0);
    check("mid_idle", eval_busy, 1'b0);
    new_input_0 = 1'b1; input_0 = 64'h55; #1;
    check("mid_new_push", q_push_valid, 1'b1);
    goto(21); new_input_0 = 1'b0; #1;
    check("mid_new_pop", q_pop, 1'b1);
    goto(22); #1;
    check("mid_new_event", {ev_data, ev_ts, layer_en}, {64'h55, 32'd20, 4'b0001});
    goto(26); #1;
    check("mid_done_cnt", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
